// File: rtl/servo_ramp_ctrl_pkg.sv
// rtl/servo_ramp_ctrl_pkg.sv - shared defaults and types for the servo ramp controller
package servo_pkg;
    localparam int NCH  = 8;
    localparam int CW   = 5;
    localparam int STEP = 1;
    localparam int CHW  = $clog2(NCH);

    typedef logic [CW-1:0] duty_t;
endpackage

// File: rtl/servo_ramp_ctrl_if.sv
// rtl/servo_ramp_ctrl_if.sv - host write port (valid/ready) for the servo ramp controller
interface servo_ramp_ctrl_if #(
    parameter int NCH = servo_pkg::NCH,
    parameter int CW  = servo_pkg::CW
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           wr_valid;
    logic           wr_ready;
    logic [CHW-1:0] wr_ch;
    logic [CW-1:0]  wr_duty;
    logic           wr_en;

    modport master (output wr_valid, wr_ch, wr_duty, wr_en, input wr_ready);
    modport slave  (input wr_valid, wr_ch, wr_duty, wr_en, output wr_ready);
endinterface

// File: rtl/servo_ramp_ctrl_frame_timer.sv
// rtl/servo_ramp_ctrl_frame_timer.sv - frame counter with period sampled at each wrap
module frame_timer #(
    parameter int CW = servo_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] period,
    output logic [CW-1:0] period_cur,
    output logic          frame_tick
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] period_q, period_d;
    logic          last;

    // A period of 0 or 1 degenerates to a one-cycle frame.
    always_comb begin
        last     = (period_q <= CW'(1)) || (cnt_q == period_q - CW'(1));
        cnt_d    = last ? '0 : cnt_q + CW'(1);
        period_d = last ? period : period_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            period_q <= period;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

    assign frame_tick = !rst && last;
    assign period_cur = period_q;
endmodule

// File: rtl/servo_ramp_ctrl.sv
// rtl/servo_ramp_ctrl.sv - 8-channel servo duty slew controller, updates applied at frame wraps
module servo_ramp_ctrl
    import servo_pkg::*;
#(
    parameter int NCH  = servo_pkg::NCH,
    parameter int CW   = servo_pkg::CW,
    parameter int STEP = servo_pkg::STEP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CW-1:0]      period,
    servo_ramp_ctrl_if.slave   wr,
    output logic [NCH*CW-1:0]  duty_bus,
    output logic [NCH-1:0]     servo,
    output logic               frame_tick,
    output logic               busy
);
    localparam logic [CW-1:0] STEP_W = CW'(STEP);

    logic [CW-1:0]  period_q;
    logic [CW-1:0]  wr_duty_lim;
    logic [NCH-1:0] wr_hit;
    logic [NCH-1:0] chan_busy;
    logic           busy_q, busy_d;

    frame_timer #(.CW(CW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .period     (period),
        .period_cur (period_q),
        .frame_tick (frame_tick)
    );

    // Writes are held off during the tick cycle so they never race a frame update.
    assign wr.wr_ready = !rst && !frame_tick;

    always_comb begin
        wr_duty_lim = (wr.wr_duty > period_q) ? period_q : wr.wr_duty;
        wr_hit      = '0;
        for (int k = 0; k < NCH; k++) begin
            wr_hit[k] = wr.wr_valid && wr.wr_ready && (int'(wr.wr_ch) == k);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] tgt_q, tgt_d, cur_q, cur_d;
        logic [CW-1:0] gap, stepped;
        logic          pend_q, pend_d, servo_q, servo_d;

        // Step is limited by the remaining distance, so the ramp never overshoots.
        always_comb begin
            tgt_d   = tgt_q;
            cur_d   = cur_q;
            pend_d  = pend_q;
            servo_d = servo_q;
            gap     = (cur_q < tgt_q) ? tgt_q - cur_q : cur_q - tgt_q;
            if (gap > STEP_W) gap = STEP_W;
            stepped = (cur_q < tgt_q) ? cur_q + gap : cur_q - gap;
            if (wr_hit[i]) begin
                tgt_d  = wr_duty_lim;
                pend_d = wr.wr_en;
            end
            if (frame_tick) begin
                servo_d = pend_q;
                tgt_d   = (tgt_q > period) ? period : tgt_q;
                cur_d   = (stepped > period) ? period : stepped;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                tgt_q   <= '0;
                cur_q   <= '0;
                pend_q  <= 1'b0;
                servo_q <= 1'b0;
            end else begin
                tgt_q   <= tgt_d;
                cur_q   <= cur_d;
                pend_q  <= pend_d;
                servo_q <= servo_d;
            end
        end

        assign duty_bus[i*CW +: CW] = cur_q;
        assign servo[i]             = servo_q;
        assign chan_busy[i]         = (cur_q != tgt_q) || (pend_q != servo_q);
    end

    always_comb begin
        busy_d = |chan_busy;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= 1'b0;
        else     busy_q <= busy_d;
    end

    assign busy = busy_q;
endmodule
